// File: rtl/bubble_pkg.sv
// Shared constants and loader state encoding for the bubble output buffer path.
package bubble_pkg;

    localparam int OUTBUF_ADDR_W    = 15;
    localparam int OUTBUF_BOOT_BASE = 0;
    localparam int OUTBUF_PAGE_BASE = 14336;
    localparam int PAGE_BITS        = 1168;

    typedef enum logic [2:0] {
        LD_IDLE      = 3'd0,
        LD_LATCH     = 3'd1,
        LD_WAIT_BYTE = 3'd2,
        LD_SHIFT     = 3'd3,
        LD_FINISH    = 3'd4
    } loader_state_e;

endpackage

// File: rtl/bubble_outbuf_loader.sv
// Serialises a byte stream into the single-bit output buffer write port.
// Build option: LOADER_LSB_FIRST_EN emits bit0 of each byte first.
module bubble_outbuf_loader
    import bubble_pkg::*;
#(
    parameter int ADDR_W = OUTBUF_ADDR_W,
    parameter int LEN_W  = 16
) (
    input  logic              MCLK,
    input  logic              nRESET,
    input  logic              START,
    input  logic [ADDR_W-1:0] START_ADDR,
    input  logic [LEN_W-1:0]  BIT_LEN,
    input  logic              ABORT,
    input  logic [7:0]        BYTE_DATA,
    input  logic              BYTE_VALID,
    output logic              BYTE_READY,
    output logic              nOUTBUFWCLKEN,
    output logic [ADDR_W-1:0] OUTBUFWADDR,
    output logic              OUTBUFWDATA,
    output logic              BUSY,
    output logic              DONE
);

    localparam logic [2:0] S_IDLE   = LD_IDLE;
    localparam logic [2:0] S_LATCH  = LD_LATCH;
    localparam logic [2:0] S_WAIT   = LD_WAIT_BYTE;
    localparam logic [2:0] S_SHIFT  = LD_SHIFT;
    localparam logic [2:0] S_FINISH = LD_FINISH;

    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  remaining_q;
    logic [2:0]        bitcnt_q;
    logic [7:0]        shreg_q;
    logic [7:0]        shreg_nx;
    logic              ready_q;
    logic              wen_n_q;
    logic              busy_q;
    logic              done_q;
    logic              take;
    logic              last_bit;

`ifdef LOADER_LSB_FIRST_EN
    assign OUTBUFWDATA = shreg_q[0];
    assign shreg_nx    = {1'b0, shreg_q[7:1]};
`else
    assign OUTBUFWDATA = shreg_q[7];
    assign shreg_nx    = {shreg_q[6:0], 1'b0};
`endif

    assign take     = (state_q == S_WAIT) && ready_q && BYTE_VALID;
    assign last_bit = (remaining_q == LEN_W'(1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (START) state_d = S_LATCH;
            end
            S_LATCH: begin
                if (remaining_q == '0) state_d = S_FINISH;
                else                   state_d = S_WAIT;
            end
            S_WAIT: begin
                if (take) state_d = S_SHIFT;
            end
            S_SHIFT: begin
                // running out of bits beats the byte boundary
                if (last_bit)                state_d = S_FINISH;
                else if (bitcnt_q == 3'd7)   state_d = S_WAIT;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (ABORT) state_d = S_IDLE;
    end

    always_ff @(posedge MCLK) begin
        if (!nRESET) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            ready_q     <= 1'b0;
            wen_n_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == S_WAIT);
            wen_n_q <= (state_d != S_SHIFT);
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_FINISH);
            if (state_q == S_IDLE && START && !ABORT) begin
                addr_q      <= START_ADDR;
                remaining_q <= BIT_LEN;
            end
            if (take) begin
                shreg_q  <= BYTE_DATA;
                bitcnt_q <= 3'd0;
            end
            // addr already shows the strobed bit; advance for the next one
            if (state_q == S_SHIFT) begin
                addr_q      <= addr_q + ADDR_W'(1);
                remaining_q <= remaining_q - LEN_W'(1);
                bitcnt_q    <= bitcnt_q + 3'd1;
                shreg_q     <= shreg_nx;
            end
        end
    end

    assign BYTE_READY    = ready_q;
    assign nOUTBUFWCLKEN = wen_n_q;
    assign OUTBUFWADDR   = addr_q;
    assign BUSY          = busy_q;
    assign DONE          = done_q;

endmodule

// File: tb/tb_bubble_outbuf_loader.sv
// Scoreboard bench for bubble_outbuf_loader: expected strobes queued at
// load start, popped by a negedge monitor as the DUT writes bits.
module tb_bubble_outbuf_loader;

    logic        MCLK = 1'b0;
    logic        nRESET;
    logic        START;
    logic [14:0] START_ADDR;
    logic [15:0] BIT_LEN;
    logic        ABORT;
    logic [7:0]  BYTE_DATA;
    logic        BYTE_VALID;
    logic        BYTE_READY;
    logic        nOUTBUFWCLKEN;
    logic [14:0] OUTBUFWADDR;
    logic        OUTBUFWDATA;
    logic        BUSY;
    logic        DONE;

    int checks = 0;
    int passed = 0;
    int strobes = 0;
    int dones = 0;
    int readies = 0;
    int consumed = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  src_q[$];

    bubble_outbuf_loader dut (
        .MCLK(MCLK),
        .nRESET(nRESET),
        .START(START),
        .START_ADDR(START_ADDR),
        .BIT_LEN(BIT_LEN),
        .ABORT(ABORT),
        .BYTE_DATA(BYTE_DATA),
        .BYTE_VALID(BYTE_VALID),
        .BYTE_READY(BYTE_READY),
        .nOUTBUFWCLKEN(nOUTBUFWCLKEN),
        .OUTBUFWADDR(OUTBUFWADDR),
        .OUTBUFWDATA(OUTBUFWDATA),
        .BUSY(BUSY),
        .DONE(DONE)
    );

    always #5 MCLK = ~MCLK;

    always @(negedge MCLK) begin
        logic [15:0] e;
        if (nOUTBUFWCLKEN === 1'b0) begin
            strobes++;
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_strobe got addr=%h data=%b", OUTBUFWADDR, OUTBUFWDATA);
            end else begin
                e = exp_q.pop_front();
                if ({OUTBUFWADDR, OUTBUFWDATA} !== e)
                    $display("FAIL strobe got addr=%h data=%b exp addr=%h data=%b",
                             OUTBUFWADDR, OUTBUFWDATA, e[15:1], e[0]);
                else passed++;
            end
        end
        if (DONE === 1'b1) dones++;
        if (BYTE_READY === 1'b1) readies++;
    end

    task automatic clear_counts();
        strobes = 0;
        dones = 0;
        readies = 0;
        exp_q.delete();
    endtask

    task automatic run_load(input logic [14:0] a, input logic [15:0] len,
                            input int stall_at, input int stall_len, input int stop_at,
                            input bit by_rst, input bit poke_start);
        int n_exp;
        int seen;
        int stall;
        int cyc;
        bit fin;
        logic [14:0] ea;
        logic [7:0] b;
        n_exp = (stop_at >= 0) ? stop_at : int'(len);
        for (int i = 0; i < n_exp; i++) begin
            ea = a + 15'(i);
            b = src_q[i / 8];
`ifdef LOADER_LSB_FIRST_EN
            exp_q.push_back({ea, b[i % 8]});
`else
            exp_q.push_back({ea, b[7 - (i % 8)]});
`endif
        end
        consumed = 0;
        seen = 0;
        stall = 0;
        fin = 0;
        @(negedge MCLK);
        START_ADDR = a;
        BIT_LEN = len;
        START = 1'b1;
        @(negedge MCLK);
        START = 1'b0;
        for (cyc = 0; cyc < 400 && !fin; cyc++) begin
            if (nOUTBUFWCLKEN === 1'b0) seen++;
            if (DONE === 1'b1) fin = 1;
            START = 1'b0;
            if (poke_start && cyc == 5) begin
                START = 1'b1;
                START_ADDR = 15'h1234;
                BIT_LEN = 16'd3;
            end
            if (stall_at >= 0 && consumed == stall_at && stall < stall_len) begin
                BYTE_VALID = 1'b0;
                stall++;
            end else if (consumed < src_q.size()) begin
                BYTE_VALID = 1'b1;
                BYTE_DATA = src_q[consumed];
                if (BYTE_READY === 1'b1) consumed++;
            end else begin
                BYTE_VALID = 1'b0;
            end
            if (stop_at >= 0 && seen == stop_at && !fin) begin
                if (by_rst) nRESET = 1'b0;
                else ABORT = 1'b1;
                @(negedge MCLK);
                nRESET = 1'b1;
                ABORT = 1'b0;
                fin = 1;
            end else if (!fin) begin
                @(negedge MCLK);
            end
        end
        START = 1'b0;
        BYTE_VALID = 1'b0;
        if (!fin) begin
            checks++;
            $display("FAIL load_timeout got no DONE/stop within 400 cycles exp completion");
        end
        repeat (3) @(negedge MCLK);
    endtask

    task automatic test_reset();
        nRESET = 1'b0;
        START = 1'b0;
        START_ADDR = '0;
        BIT_LEN = '0;
        ABORT = 1'b0;
        BYTE_DATA = '0;
        BYTE_VALID = 1'b0;
        repeat (3) @(negedge MCLK);
        checks++; if (BYTE_READY !== 1'b0) $display("FAIL rst_ready got %b exp 0", BYTE_READY); else passed++;
        checks++; if (nOUTBUFWCLKEN !== 1'b1) $display("FAIL rst_wen got %b exp 1", nOUTBUFWCLKEN); else passed++;
        checks++; if (OUTBUFWADDR !== 15'h0) $display("FAIL rst_addr got %h exp 0", OUTBUFWADDR); else passed++;
        checks++; if (OUTBUFWDATA !== 1'b0) $display("FAIL rst_data got %b exp 0", OUTBUFWDATA); else passed++;
        checks++; if (BUSY !== 1'b0) $display("FAIL rst_busy got %b exp 0", BUSY); else passed++;
        checks++; if (DONE !== 1'b0) $display("FAIL rst_done got %b exp 0", DONE); else passed++;
        nRESET = 1'b1;
        repeat (2) @(negedge MCLK);
    endtask

    task automatic test_basic();
        clear_counts();
        src_q = '{8'hA5, 8'h3C};
        run_load(15'h0000, 16'd16, -1, 0, -1, 1'b0, 1'b1);
        checks++; if (strobes !== 16) $display("FAIL basic_strobes got %0d exp 16", strobes); else passed++;
        checks++; if (exp_q.size() !== 0) $display("FAIL basic_left got %0d exp 0", exp_q.size()); else passed++;
        checks++; if (dones !== 1) $display("FAIL basic_done got %0d exp 1", dones); else passed++;
        checks++; if (BUSY !== 1'b0) $display("FAIL basic_busy got %b exp 0", BUSY); else passed++;
    endtask

    task automatic test_empty();
        clear_counts();
        @(negedge MCLK);
        START_ADDR = 15'h0040;
        BIT_LEN = 16'd0;
        START = 1'b1;
        @(negedge MCLK);
        START = 1'b0;
        checks++; if ({BUSY, DONE} !== 2'b10) $display("FAIL empty_c1 got busy,done=%b%b exp 10", BUSY, DONE); else passed++;
        @(negedge MCLK);
        checks++; if (DONE !== 1'b1) $display("FAIL empty_done got %b exp 1", DONE); else passed++;
        @(negedge MCLK);
        checks++; if ({BUSY, DONE} !== 2'b00) $display("FAIL empty_c3 got busy,done=%b%b exp 00", BUSY, DONE); else passed++;
        repeat (2) @(negedge MCLK);
        checks++; if (strobes !== 0) $display("FAIL empty_strobes got %0d exp 0", strobes); else passed++;
        checks++; if (readies !== 0) $display("FAIL empty_ready got %0d exp 0", readies); else passed++;
    endtask

    task automatic test_wrap();
        clear_counts();
        src_q = '{8'hF0, 8'h11};
        run_load(15'h7FFE, 16'd4, -1, 0, -1, 1'b0, 1'b0);
        checks++; if (strobes !== 4) $display("FAIL wrap_strobes got %0d exp 4", strobes); else passed++;
        checks++; if (exp_q.size() !== 0) $display("FAIL wrap_left got %0d exp 0", exp_q.size()); else passed++;
        checks++; if (consumed !== 1) $display("FAIL wrap_bytes got %0d exp 1", consumed); else passed++;
        checks++; if (dones !== 1) $display("FAIL wrap_done got %0d exp 1", dones); else passed++;
    endtask

    task automatic test_stall();
        clear_counts();
        src_q = '{8'h69, 8'hC3, 8'h5E};
        run_load(15'h0123, 16'd24, 1, 30, -1, 1'b0, 1'b0);
        checks++; if (strobes !== 24) $display("FAIL stall_strobes got %0d exp 24", strobes); else passed++;
        checks++; if (exp_q.size() !== 0) $display("FAIL stall_left got %0d exp 0", exp_q.size()); else passed++;
        checks++; if (dones !== 1) $display("FAIL stall_done got %0d exp 1", dones); else passed++;
    endtask

    task automatic test_abort(input bit by_rst);
        clear_counts();
        src_q = '{8'h96, 8'h3C, 8'hFF};
        run_load(15'h0200, 16'd24, -1, 0, 10, by_rst, 1'b0);
        checks++; if (strobes !== 10) $display("FAIL abort_strobes rst=%0d got %0d exp 10", by_rst, strobes); else passed++;
        checks++; if (dones !== 0) $display("FAIL abort_done rst=%0d got %0d exp 0", by_rst, dones); else passed++;
        checks++; if ({BUSY, BYTE_READY, nOUTBUFWCLKEN} !== 3'b001)
            $display("FAIL abort_idle rst=%0d got %b exp 001", by_rst, {BUSY, BYTE_READY, nOUTBUFWCLKEN}); else passed++;
        if (by_rst) begin
            checks++; if (OUTBUFWADDR !== 15'h0) $display("FAIL rst_mid_addr got %h exp 0", OUTBUFWADDR); else passed++;
        end
        clear_counts();
        src_q = '{8'h5A};
        run_load(15'd100, 16'd8, -1, 0, -1, 1'b0, 1'b0);
        checks++; if (strobes !== 8) $display("FAIL reload_strobes got %0d exp 8", strobes); else passed++;
        checks++; if (dones !== 1) $display("FAIL reload_done got %0d exp 1", dones); else passed++;
    endtask

    task automatic test_start_abort_idle();
        clear_counts();
        @(negedge MCLK);
        START_ADDR = 15'h0777;
        BIT_LEN = 16'd8;
        START = 1'b1;
        ABORT = 1'b1;
        @(negedge MCLK);
        START = 1'b0;
        ABORT = 1'b0;
        checks++; if (BUSY !== 1'b0) $display("FAIL start_abort_busy got %b exp 0", BUSY); else passed++;
        repeat (3) @(negedge MCLK);
        checks++; if (readies !== 0) $display("FAIL start_abort_ready got %0d exp 0", readies); else passed++;
    endtask

    task automatic test_bit_order();
        clear_counts();
        src_q = '{8'h01};
        run_load(15'h0300, 16'd8, -1, 0, -1, 1'b0, 1'b0);
        checks++; if (strobes !== 8) $display("FAIL order_strobes got %0d exp 8", strobes); else passed++;
        checks++; if (exp_q.size() !== 0) $display("FAIL order_left got %0d exp 0", exp_q.size()); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_wrap();
        test_stall();
        test_abort(1'b0);
        test_abort(1'b1);
        test_start_abort_idle();
        test_bit_order();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
